// File: rtl/pif_ram_controller_pkg.sv
// Shared definitions for the PIF RAM controller: region constants, command states,
// serial-interface transfer codes, the compiled-in boot image and byte-lane helpers.
package pif_ram_controller_pkg;

    localparam logic [8:0]  PIF_RAM_BASE       = 9'h1F0;
    localparam logic [8:0]  PIF_CMD_WORD       = 9'h1FF;
    localparam logic [5:0]  PIF_CMD_BYTE       = 6'd63;
    localparam logic [31:0] PIF_BOOT_SIGNATURE = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        CMD_IDLE    = 2'd0,
        CMD_PENDING = 2'd1,
        CMD_SERVICE = 2'd2
    } cmd_state_t;

    typedef enum logic [1:0] {
        XFER_NONE     = 2'd0,
        XFER_READ_64  = 2'd1,
        XFER_WRITE_64 = 2'd2,
        XFER_WORD     = 2'd3
    } pif_xfer_t;

    // Word 0x010 carries the boot signature; every other word encodes its own address.
    function automatic logic [31:0] pif_boot_image(input logic [8:0] addr);
        if (addr == 9'h010)
            return PIF_BOOT_SIGNATURE;
        return {16'hB007, 7'h00, addr};
    endfunction

    // Big-endian lanes: lane 0 is bits [31:24].
    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] lane);
        case (lane)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] value);
        logic [31:0] merged;
        merged = word;
        case (lane)
            2'd0:    merged[31:24] = value;
            2'd1:    merged[23:16] = value;
            2'd2:    merged[15:8]  = value;
            default: merged[7:0]   = value;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/pif_ram_controller_boot_rom.sv
// Combinational-read boot ROM. The image is compiled in from pif_boot_image;
// an empty ROM_INIT_FILE builds a blank ROM.
module pif_boot_rom
    import pif_ram_controller_pkg::*;
#(
    parameter int    ROM_WORDS     = 496,
    parameter string ROM_INIT_FILE = "pif_boot.hex"
) (
    input  logic [8:0]  addr,
    output logic [31:0] rd_data
);

    localparam logic [9:0] ROM_LIMIT = 10'(ROM_WORDS);

    logic in_range;

    assign in_range = ({1'b0, addr} < ROM_LIMIT);

    if (ROM_INIT_FILE == "") begin : g_blank
        assign rd_data = '0;
    end else begin : g_image
        assign rd_data = in_range ? pif_boot_image(addr) : 32'h0;
    end

endmodule

// File: rtl/pif_ram_controller.sv
// PIF boot ROM + 64-byte PIF RAM with N64 word port, CPU byte port and command handshake.
// Optional feature macro: PIF_CMD_IRQ_EN (registered cmd_irq pulse on each new command).
module pif_ram_controller
    import pif_ram_controller_pkg::*;
#(
    parameter int    ROM_WORDS     = 496,
    parameter int    RAM_WORDS     = 16,
    parameter string ROM_INIT_FILE = "pif_boot.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  n64_address,
    input  logic        n64_wren,
    input  logic [31:0] n64_data_in,
    output logic [31:0] n64_data_out,
    input  logic        pif_disable,
    input  logic [5:0]  cpu_address,
    input  logic        cpu_wren,
    input  logic        cpu_rden,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_valid,
    output logic        cpu_write_drop,
    output logic        cmd_pending,
    output logic        cmd_irq
);

    localparam int                RAM_AW     = $clog2(RAM_WORDS);
    localparam logic [9:0]        ROM_LIMIT  = 10'(ROM_WORDS);
    localparam logic [8:0]        RAM_SPAN   = 9'(RAM_WORDS);
    localparam logic [RAM_AW-1:0] CLEAR_LAST = RAM_AW'(RAM_WORDS - 1);

    logic [31:0]       ram [RAM_WORDS];
    logic              clear_active;
    logic [RAM_AW-1:0] clear_idx;

    logic [31:0]       rom_word;
    logic [8:0]        n64_off;
    logic              n64_in_rom;
    logic              n64_in_ram;
    logic [RAM_AW-1:0] n64_idx;

    logic [RAM_AW-1:0] cpu_idx;
    logic [1:0]        cpu_lane;
    logic [31:0]       cpu_word;

    logic              wr_open;
    logic              n64_ram_wr;
    logic              cpu_collide;
    logic              cpu_ram_wr;

    cmd_state_t        cmd_state;
    cmd_state_t        cmd_next;

    pif_boot_rom #(
        .ROM_WORDS     (ROM_WORDS),
        .ROM_INIT_FILE (ROM_INIT_FILE)
    ) u_boot_rom (
        .addr    (n64_address),
        .rd_data (rom_word)
    );

    assign n64_off    = n64_address - PIF_RAM_BASE;
    assign n64_in_rom = ({1'b0, n64_address} < ROM_LIMIT);
    assign n64_in_ram = (n64_address >= PIF_RAM_BASE) && (n64_off < RAM_SPAN);
    assign n64_idx    = n64_off[RAM_AW-1:0];

    assign cpu_idx  = RAM_AW'(cpu_address[5:2]);
    assign cpu_lane = cpu_address[1:0];
    assign cpu_word = ram[cpu_idx];

    // Zero-latency read path: the serial interface samples the next word back to back.
    always_comb begin
        n64_data_out = 32'h0;
        if (n64_in_rom)
            n64_data_out = pif_disable ? 32'h0 : rom_word;
        else if (n64_in_ram)
            n64_data_out = ram[n64_idx];
    end

    // Both ports are shut while reset or the post-reset clear is running.
    assign wr_open     = !reset && !clear_active;
    assign n64_ram_wr  = wr_open && n64_wren && n64_in_ram;
    assign cpu_collide = n64_ram_wr && cpu_wren && (cpu_idx == n64_idx);
    assign cpu_ram_wr  = wr_open && cpu_wren && !cpu_collide;

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_active <= 1'b1;
            clear_idx    <= '0;
        end else if (clear_active) begin
            clear_idx <= clear_idx + RAM_AW'(1);
            if (clear_idx == CLEAR_LAST)
                clear_active <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_active) begin
            ram[clear_idx] <= 32'h0;
        end else begin
            if (n64_ram_wr)
                ram[n64_idx] <= n64_data_in;
            if (cpu_ram_wr)
                ram[cpu_idx] <= put_byte(cpu_word, cpu_lane, cpu_data_in);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_valid      <= 1'b0;
            cpu_data_out   <= 8'h00;
            cpu_write_drop <= 1'b0;
        end else begin
            cpu_valid      <= cpu_rden;
            cpu_write_drop <= cpu_collide;
            if (cpu_rden)
                cpu_data_out <= get_byte(cpu_word, cpu_lane);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            cmd_state <= CMD_IDLE;
        else
            cmd_state <= cmd_next;
    end

    // Completion needs the CPU byte to actually land; a dropped write leaves SERVICE.
    always_comb begin
        cmd_next = cmd_state;
        case (cmd_state)
            CMD_IDLE: begin
                if (n64_ram_wr && (n64_address == PIF_CMD_WORD) && (n64_data_in[7:0] != 8'h00))
                    cmd_next = CMD_PENDING;
            end
            CMD_PENDING: begin
                if (cpu_rden && (cpu_address == PIF_CMD_BYTE))
                    cmd_next = CMD_SERVICE;
            end
            CMD_SERVICE: begin
                if (cpu_ram_wr && (cpu_address == PIF_CMD_BYTE))
                    cmd_next = CMD_IDLE;
            end
            default: cmd_next = CMD_IDLE;
        endcase
    end

    assign cmd_pending = (cmd_state == CMD_PENDING) || (cmd_state == CMD_SERVICE);

`ifdef PIF_CMD_IRQ_EN
    logic cmd_irq_q;

    always_ff @(posedge clk) begin
        if (reset)
            cmd_irq_q <= 1'b0;
        else
            cmd_irq_q <= (cmd_state == CMD_IDLE) && (cmd_next == CMD_PENDING);
    end

    assign cmd_irq = cmd_irq_q;
`else
    assign cmd_irq = 1'b0;
`endif

endmodule

// File: tb/tb_pif_ram_controller.sv
// Testbench for pif_ram_controller: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a byte-level reference model.
module tb_pif_ram_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  n64_address;
    logic        n64_wren;
    logic [31:0] n64_data_in;
    logic [31:0] n64_data_out;
    logic        pif_disable;
    logic [5:0]  cpu_address;
    logic        cpu_wren;
    logic        cpu_rden;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_data_out;
    logic        cpu_valid;
    logic        cpu_write_drop;
    logic        cmd_pending;
    logic        cmd_irq;

    always #5 clk = ~clk;

    pif_ram_controller dut (
        .clk            (clk),
        .reset          (reset),
        .n64_address    (n64_address),
        .n64_wren       (n64_wren),
        .n64_data_in    (n64_data_in),
        .n64_data_out   (n64_data_out),
        .pif_disable    (pif_disable),
        .cpu_address    (cpu_address),
        .cpu_wren       (cpu_wren),
        .cpu_rden       (cpu_rden),
        .cpu_data_in    (cpu_data_in),
        .cpu_data_out   (cpu_data_out),
        .cpu_valid      (cpu_valid),
        .cpu_write_drop (cpu_write_drop),
        .cmd_pending    (cmd_pending),
        .cmd_irq        (cmd_irq)
    );

`ifdef PIF_CMD_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: 64 bytes, a command state 0/1/2, and a clear countdown.
    logic [7:0] m_mem [64];
    int         m_state = 0;
    int         m_clear = 0;
    bit         m_ready = 1'b0;
    bit         m_data_known = 1'b0;
    logic       m_valid, m_drop, m_irq;
    logic [7:0] m_data;
    int         m_w;
    bit         m_hit, m_col;

    function automatic logic [31:0] m_word(input int w);
        return {m_mem[4*w], m_mem[4*w+1], m_mem[4*w+2], m_mem[4*w+3]};
    endfunction

    function automatic logic [31:0] m_read(input logic [8:0] a, input logic dis);
        if (int'(a) < 496) begin
            if (dis)
                return 32'h0;
            return (a == 9'h010) ? 32'hDEADBEEF : (32'hB0070000 | 32'(a));
        end
        return m_word(int'(a) - 496);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++)
                m_mem[i] = 8'h00;
            m_state      = 0;
            m_clear      = 16;
            m_valid      = 1'b0;
            m_data       = 8'h00;
            m_data_known = 1'b1;
            m_drop       = 1'b0;
            m_irq        = 1'b0;
            m_ready      = 1'b1;
        end else if (m_ready) begin
            m_valid = cpu_rden;
            m_irq   = 1'b0;
            m_drop  = 1'b0;
            if (m_clear > 0) begin
                m_clear--;
                if (cpu_rden)
                    m_data_known = 1'b0;
            end else begin
                if (cpu_rden) begin
                    m_data       = m_mem[cpu_address];
                    m_data_known = 1'b1;
                end
                m_hit  = n64_wren && (int'(n64_address) >= 496);
                m_w    = int'(n64_address) - 496;
                m_col  = m_hit && cpu_wren && (int'(cpu_address) / 4 == m_w);
                m_drop = m_col;
                if (m_hit) begin
                    m_mem[4*m_w]   = n64_data_in[31:24];
                    m_mem[4*m_w+1] = n64_data_in[23:16];
                    m_mem[4*m_w+2] = n64_data_in[15:8];
                    m_mem[4*m_w+3] = n64_data_in[7:0];
                end
                if (cpu_wren && !m_col)
                    m_mem[cpu_address] = cpu_data_in;
                if (m_state == 0) begin
                    if (m_hit && n64_address == 9'h1FF && n64_data_in[7:0] != 8'h00) begin
                        m_state = 1;
                        m_irq   = IRQ_EN;
                    end
                end else if (m_state == 1) begin
                    if (cpu_rden && cpu_address == 6'd63)
                        m_state = 2;
                end else begin
                    if (cpu_wren && !m_col && cpu_address == 6'd63)
                        m_state = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("cmd_pending", 32'(cmd_pending), 32'(m_state != 0));
            check("cpu_valid", 32'(cpu_valid), 32'(m_valid));
            check("cpu_write_drop", 32'(cpu_write_drop), 32'(m_drop));
            check("cmd_irq", 32'(cmd_irq), 32'(m_irq));
            if (m_data_known)
                check("cpu_data_out", 32'(cpu_data_out), 32'(m_data));
            if (m_clear == 0 && !reset)
                check("n64_data_out", n64_data_out, m_read(n64_address, pif_disable));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        n64_wren = 1'b0;
        cpu_wren = 1'b0;
        cpu_rden = 1'b0;
    endtask

    task automatic n64_wr(input logic [8:0] a, input logic [31:0] d);
        n64_address = a;
        n64_data_in = d;
        n64_wren    = 1'b1;
        step();
        n64_wren    = 1'b0;
    endtask

    task automatic n64_rd_check(input string name, input logic [8:0] a, input logic [31:0] want);
        n64_address = a;
        @(negedge clk);
        check(name, n64_data_out, want);
        step();
    endtask

    task automatic cpu_wr(input logic [5:0] a, input logic [7:0] d);
        cpu_address = a;
        cpu_data_in = d;
        cpu_wren    = 1'b1;
        step();
        cpu_wren    = 1'b0;
    endtask

    task automatic cpu_rd(input string name, input logic [5:0] a, input logic [7:0] want);
        cpu_address = a;
        cpu_rden    = 1'b1;
        step();
        cpu_rden    = 1'b0;
        @(negedge clk);
        check(name, 32'(cpu_data_out), 32'(want));
        check({name, "_valid"}, 32'(cpu_valid), 32'd1);
        step();
    endtask

    task automatic expect_now(input string name, input logic got, input logic want);
        @(negedge clk);
        check(name, 32'(got), 32'(want));
        step();
    endtask

    logic [7:0] t2_bytes [4];

    initial begin
        reset       = 1'b1;
        n64_address = 9'h000;
        n64_data_in = 32'h0;
        pif_disable = 1'b0;
        cpu_address = 6'd0;
        cpu_data_in = 8'h00;
        idle();
        repeat (3) step();
        @(negedge clk);
        check("rst_cmd_pending", 32'(cmd_pending), 32'd0);
        check("rst_cpu_valid", 32'(cpu_valid), 32'd0);
        check("rst_cpu_data_out", 32'(cpu_data_out), 32'd0);
        check("rst_write_drop", 32'(cpu_write_drop), 32'd0);
        check("rst_cmd_irq", 32'(cmd_irq), 32'd0);
        step();
        reset = 1'b0;
        repeat (18) step();

        // Scenario 1: cleared RAM
        for (int i = 0; i < 16; i++)
            n64_rd_check("t1_ram_zero", 9'h1F0 + 9'(i), 32'h0);
        cpu_rd("t1_cpu_byte5", 6'd5, 8'h00);

        // Scenario 2: byte order and byte merge
        n64_wr(9'h1F1, 32'hA1B2C3D4);
        t2_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++)
            cpu_rd("t2_cpu_byte", 6'(4 + i), t2_bytes[i]);
        cpu_wr(6'd6, 8'h55);
        n64_rd_check("t2_merged_word", 9'h1F1, 32'hA1B255D4);

        // Scenario 3: ROM and lockout
        pif_disable = 1'b0;
        n64_rd_check("t3_rom_sig", 9'h010, 32'hDEADBEEF);
        pif_disable = 1'b1;
        n64_rd_check("t3_rom_locked", 9'h010, 32'h0);
        n64_wr(9'h1F5, 32'h12345678);
        n64_rd_check("t3_ram_unlocked", 9'h1F5, 32'h12345678);
        pif_disable = 1'b0;
        n64_wr(9'h010, 32'h0);
        n64_rd_check("t3_rom_write_ignored", 9'h010, 32'hDEADBEEF);
        n64_rd_check("t3_rom_last", 9'h1EF, 32'hB00701EF);

        // Scenario 4: command handshake
        n64_wr(9'h1FF, 32'h00000001);
        @(negedge clk);
        check("t4_pending_set", 32'(cmd_pending), 32'd1);
        check("t4_irq_pulse", 32'(cmd_irq), 32'(IRQ_EN));
        step();
        expect_now("t4_irq_single", cmd_irq, 1'b0);
        cpu_rd("t4_cmd_byte", 6'd63, 8'h01);
        n64_wr(9'h1FF, 32'h00000007);
        expect_now("t4_service_held", cmd_pending, 1'b1);
        cpu_wr(6'd63, 8'h00);
        expect_now("t4_pending_clear", cmd_pending, 1'b0);
        n64_wr(9'h1FF, 32'h0);
        expect_now("t4_zero_cmd", cmd_pending, 1'b0);
        n64_wr(9'h1FF, 32'h00000003);
        cpu_wr(6'd63, 8'h44);
        expect_now("t4_pending_cpu_wr", cmd_pending, 1'b1);
        cpu_rd("t4_cmd_byte_stored", 6'd63, 8'h44);
        cpu_wr(6'd63, 8'h00);
        expect_now("t4_done", cmd_pending, 1'b0);

        // Scenario 5: same-cycle N64/CPU writes
        n64_address = 9'h1F3; n64_data_in = 32'h11223344; n64_wren = 1'b1;
        cpu_address = 6'd13;  cpu_data_in = 8'hFF;        cpu_wren = 1'b1;
        step();
        idle();
        expect_now("t5_drop_pulse", cpu_write_drop, 1'b1);
        n64_rd_check("t5_n64_wins", 9'h1F3, 32'h11223344);
        n64_address = 9'h1F3; n64_data_in = 32'hAABBCCDD; n64_wren = 1'b1;
        cpu_address = 6'd20;  cpu_data_in = 8'h77;        cpu_wren = 1'b1;
        step();
        idle();
        expect_now("t5_no_drop", cpu_write_drop, 1'b0);
        n64_rd_check("t5_n64_lands", 9'h1F3, 32'hAABBCCDD);
        n64_rd_check("t5_cpu_lands", 9'h1F5, 32'h77345678);
        cpu_address = 6'd20; cpu_data_in = 8'h99; cpu_rden = 1'b1; cpu_wren = 1'b1;
        step();
        idle();
        @(negedge clk);
        check("t5_rdw_old", 32'(cpu_data_out), 32'h77);
        step();
        cpu_rd("t5_rdw_new", 6'd20, 8'h99);

        // Scenario 6: reset in SERVICE and mid-clear
        n64_wr(9'h1FF, 32'h00000005);
        cpu_rd("t6_cmd_byte", 6'd63, 8'h05);
        reset = 1'b1;
        step();
        @(negedge clk);
        check("t6_pending_reset", 32'(cmd_pending), 32'd0);
        step();
        reset = 1'b0;
        repeat (5) step();
        n64_wr(9'h1F2, 32'hFFFFFFFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        n64_wr(9'h1F4, 32'h00000001);
        repeat (14) step();
        for (int i = 0; i < 16; i++)
            n64_rd_check("t6_ram_zero", 9'h1F0 + 9'(i), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            n64_wren    = ($urandom_range(0, 99) < 30);
            n64_address = ($urandom_range(0, 9) < 7) ? (9'h1F0 | 9'($urandom_range(0, 15)))
                                                     : 9'($urandom_range(0, 511));
            n64_data_in = $urandom;
            if ($urandom_range(0, 1) == 0)
                n64_data_in[7:0] = 8'h00;
            cpu_wren    = ($urandom_range(0, 99) < 25);
            cpu_rden    = ($urandom_range(0, 99) < 35);
            cpu_address = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0)
                cpu_address = {n64_address[3:0], 2'($urandom_range(0, 3))};
            cpu_data_in = 8'($urandom);
            pif_disable = 1'($urandom_range(0, 1));
            if (c % 700 == 699) begin
                idle();
                reset = 1'b1;
                step();
                reset = 1'b0;
                repeat (17) step();
            end else begin
                step();
            end
        end

        idle();
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
